// File: rtl/seven_segment_pkg.sv
// Shared definitions for seven-segment display blocks: display types,
// hex segment table and the chain controller state encoding.
package seven_segment_pkg;

  localparam logic [7:0] TYPE_RAW = 8'h00;
  localparam logic [7:0] TYPE_HEX = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE
  } state_t;

  // Segments a..g in bits 0..6, active-high.
  function automatic logic [6:0] hex_segments(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_encoder.sv
// Combinational encoder: one 16-bit buffer entry (type in [15:8], data in [7:0])
// to an 8-bit segment pattern with dp in bit 7.
module seven_segment_encoder
  import seven_segment_pkg::*;
(
  input  logic [15:0] entry,
  output logic [7:0]  seg
);

  always_comb begin
    seg = 8'h00;
    case (entry[15:8])
      TYPE_RAW: seg = entry[7:0];
      TYPE_HEX: seg = {entry[7], hex_segments(entry[3:0])};
      default:  seg = 8'h00;
    endcase
  end

endmodule

// File: rtl/seven_segment_chain_ctrl.sv
// Digit buffer plus frame sequencer that shifts encoded patterns out over a
// data / shift-clock / latch chain whenever the buffer has changed.
module seven_segment_chain_ctrl
  import seven_segment_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int CLK_DIV  = 4,
  parameter int ADDR_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              ser_data,
  output logic              ser_clk,
  output logic              ser_latch
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [15:0]       buffer [N_DIGITS];
  state_t            state_reg, state_next;
  logic              dirty_reg, dirty_next;
  logic [PH_W-1:0]   phase_reg, phase_next;
  logic              half_reg, half_next;
  logic [2:0]        bit_reg, bit_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [7:0]        shreg_reg, shreg_next;
  logic              busy_next, done_next, ser_data_next, ser_clk_next, ser_latch_next;
  logic              wr_valid;
  logic              phase_last;
  logic [15:0]       cur_entry;
  logic [7:0]        cur_seg;

  assign wr_valid   = wr_en && (int'(wr_addr) < N_DIGITS);
  assign phase_last = (phase_reg == PH_W'(CLK_DIV - 1));
  assign cur_entry  = buffer[idx_reg];

  seven_segment_encoder u_encoder (
    .entry (cur_entry),
    .seg   (cur_seg)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < N_DIGITS; i++) buffer[i] <= '0;
    end else if (wr_valid) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    dirty_next = dirty_reg;
    phase_next = phase_reg;
    half_next  = half_reg;
    bit_next   = bit_reg;
    idx_next   = idx_reg;
    shreg_next = shreg_reg;
    case (state_reg)
      ST_IDLE: begin
        if (dirty_reg) begin
          dirty_next = 1'b0;
          idx_next   = ADDR_W'(N_DIGITS - 1);
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shreg_next = cur_seg;
        phase_next = '0;
        half_next  = 1'b0;
        bit_next   = 3'd0;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!phase_last) begin
          phase_next = phase_reg + PH_W'(1);
        end else if (!half_reg) begin
          phase_next = '0;
          half_next  = 1'b1;
        end else begin
          // End of the high phase: falling ser_clk, advance to the next bit.
          phase_next = '0;
          half_next  = 1'b0;
          shreg_next = {shreg_reg[6:0], 1'b0};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            if (idx_reg == '0) begin
              state_next = ST_LATCH;
            end else begin
              idx_next   = idx_reg - ADDR_W'(1);
              state_next = ST_LOAD;
            end
          end
        end
      end
      ST_LATCH: begin
        if (phase_last) begin
          phase_next = '0;
          state_next = ST_DONE;
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // A write landing in the same cycle as the IDLE decision keeps dirty set.
    if (wr_valid) dirty_next = 1'b1;

    busy_next      = (state_next != ST_IDLE);
    done_next      = (state_next == ST_DONE);
    ser_data_next  = (state_next == ST_SHIFT) && shreg_next[7];
    ser_clk_next   = (state_next == ST_SHIFT) && half_next;
    ser_latch_next = (state_next == ST_LATCH);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      dirty_reg <= 1'b1;
      phase_reg <= '0;
      half_reg  <= 1'b0;
      bit_reg   <= 3'd0;
      idx_reg   <= '0;
      shreg_reg <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      ser_data  <= 1'b0;
      ser_clk   <= 1'b0;
      ser_latch <= 1'b0;
    end else begin
      state_reg <= state_next;
      dirty_reg <= dirty_next;
      phase_reg <= phase_next;
      half_reg  <= half_next;
      bit_reg   <= bit_next;
      idx_reg   <= idx_next;
      shreg_reg <= shreg_next;
      busy      <= busy_next;
      done      <= done_next;
      ser_data  <= ser_data_next;
      ser_clk   <= ser_clk_next;
      ser_latch <= ser_latch_next;
    end
  end

endmodule

// File: tb/tb_seven_segment_chain_ctrl.sv
// Directed bench: a 4-digit chain (CLK_DIV=4) and a 3-digit chain (CLK_DIV=2),
// each observed through a shift-register model of the display board.
module tb_seven_segment_chain_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn;
  logic        wr_en, wr_en3;
  logic [1:0]  wr_addr, wr_addr3;
  logic [15:0] wr_data, wr_data3;
  logic        busy, done, ser_data, ser_clk, ser_latch;
  logic        busy3, done3, ser_data3, ser_clk3, ser_latch3;

  seven_segment_chain_ctrl #(.N_DIGITS(4), .CLK_DIV(4), .ADDR_W(2)) dut (
    .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch)
  );

  seven_segment_chain_ctrl #(.N_DIGITS(3), .CLK_DIV(2), .ADDR_W(2)) dut3 (
    .clock(clock), .resetn(resetn), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .busy(busy3), .done(done3), .ser_data(ser_data3), .ser_clk(ser_clk3), .ser_latch(ser_latch3)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Board model: one chain register per DUT, sampled on the falling clock edge.
  logic [1:0]  v_busy, v_done, v_data, v_clk, v_latch;
  assign v_busy  = {busy3, busy};
  assign v_done  = {done3, done};
  assign v_data  = {ser_data3, ser_data};
  assign v_clk   = {ser_clk3, ser_clk};
  assign v_latch = {ser_latch3, ser_latch};

  logic [31:0] chain [2];
  logic [31:0] latch_hist [2][16];
  logic        prev_clk [2];
  logic        prev_latch [2];
  int nbits [2];
  int cyc [2];
  int frame_len [2];
  int frame_bits [2];
  int latch_run [2];
  int latch_len [2];
  int latch_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        chain[k] = 32'h0;
        nbits[k] = 0;
        cyc[k] = 0;
        latch_run[k] = 0;
        prev_clk[k] = 1'b0;
        prev_latch[k] = 1'b0;
      end else begin
        if (v_clk[k] && !prev_clk[k]) begin
          chain[k] = {chain[k][30:0], v_data[k]};
          nbits[k]++;
        end
        if (v_latch[k]) latch_run[k]++;
        if (!v_latch[k] && prev_latch[k]) begin
          latch_hist[k][latch_cnt[k] % 16] = chain[k];
          latch_len[k] = latch_run[k];
          latch_run[k] = 0;
          latch_cnt[k]++;
        end
        if (v_busy[k]) cyc[k]++;
        if (v_done[k]) begin
          frame_len[k] = cyc[k];
          frame_bits[k] = nbits[k];
          cyc[k] = 0;
          nbits[k] = 0;
          done_cnt[k]++;
        end
        prev_clk[k] = v_clk[k];
        prev_latch[k] = v_latch[k];
      end
    end
  end

  function automatic logic [31:0] last_latch(input int k);
    return latch_hist[k][(latch_cnt[k] - 1) % 16];
  endfunction

  task automatic write(input int k, input logic [1:0] a, input logic [15:0] d);
    if (k == 0) begin
      wr_en = 1'b1; wr_addr = a; wr_data = d;
    end else begin
      wr_en3 = 1'b1; wr_addr3 = a; wr_data3 = d;
    end
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    wr_en3 = 1'b0;
  endtask

  // Wait until the DUT has been idle for 4 cycles; reports frames completed meanwhile.
  task automatic wait_idle(input int k, output int frames);
    int d0;
    int run;
    d0 = done_cnt[k];
    run = 0;
    for (int i = 0; i < 3000 && run < 4; i++) begin
      @(negedge clock);
      #1;
      if (v_busy[k]) run = 0;
      else run++;
    end
    check_val("settle_in_time", 32'(run >= 4), 32'd1);
    frames = done_cnt[k] - d0;
  endtask

  task automatic wait_busy(input int k);
    int seen;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clock);
      #1;
      if (v_busy[k]) seen = 1;
    end
    check_val("frame_start", 32'(seen), 32'd1);
  endtask

  int f;
  int lpre;
  int busy_seen;
  logic [31:0] frame1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'h0;
    wr_en3 = 1'b0; wr_addr3 = 2'd0; wr_data3 = 16'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("reset_outputs", 32'({busy, done, ser_data, ser_clk, ser_latch}), 32'd0);

    // Blanking frame right after reset release.
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    check_val("busy_first_cycle", 32'(busy), 32'd1);
    wait_idle(0, f);
    check_val("blank_frames", 32'(f), 32'd1);
    check_val("blank_frame_len", 32'(frame_len[0]), 32'd265);
    check_val("blank_bits", 32'(frame_bits[0]), 32'd32);
    check_val("blank_latched", last_latch(0), 32'h0000_0000);
    check_val("latch_width", 32'(latch_len[0]), 32'd4);
    check_val("latch_count", 32'(latch_cnt[0]), 32'd1);
    check_val("idle_busy", 32'(busy), 32'd0);

    // Hex and raw digits; the second write coincides with the IDLE decision.
    write(0, 2'd0, 16'h0105);
    write(0, 2'd3, 16'h00A5);
    wait_idle(0, f);
    check_val("hexraw_frames", 32'(f), 32'd2);
    check_val("hexraw_latched", last_latch(0), 32'hA500_006D);

    write(0, 2'd1, 16'h0188);
    write(0, 2'd2, 16'h0788);
    wait_idle(0, f);
    check_val("dp_blank_latched", last_latch(0), 32'hA500_FF6D);

    write(0, 2'd3, 16'h010A);
    wait_idle(0, f);
    check_val("single_frames", 32'(f), 32'd1);
    check_val("hexA_latched", last_latch(0), 32'h7700_FF6D);

    // Writes to digit 2 during its own shift and during digit 1's shift.
    write(0, 2'd0, 16'h0003);
    wait_busy(0);
    repeat (79) @(negedge clock);
    write(0, 2'd2, 16'h0102);
    repeat (70) @(negedge clock);
    write(0, 2'd2, 16'h0104);
    lpre = latch_cnt[0];
    wait_idle(0, f);
    check_val("midframe_frames", 32'(f), 32'd2);
    frame1 = latch_hist[0][lpre % 16];
    check_val("midframe_first", frame1, 32'h7700_FF03);
    check_val("midframe_second", last_latch(0), 32'h7766_FF03);

    // One-cycle reset in the middle of a shift.
    write(0, 2'd1, 16'h0109);
    wait_busy(0);
    repeat (30) @(negedge clock);
    lpre = latch_cnt[0];
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    check_val("abort_outputs", 32'({busy, done, ser_data, ser_clk, ser_latch}), 32'd0);
    check_val("abort_no_latch", 32'(latch_cnt[0]), 32'(lpre));
    wait_idle(0, f);
    check_val("reblank_frames", 32'(f), 32'd1);
    check_val("reblank_latch_count", 32'(latch_cnt[0]), 32'(lpre + 1));
    check_val("reblank_latched", last_latch(0), 32'h0000_0000);
    check_val("reblank_len", 32'(frame_len[0]), 32'd265);

    // Three-digit chain: out-of-range address is ignored.
    wait_idle(1, f);
    write(1, 2'd3, 16'h00FF);
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      #1;
      if (busy3) busy_seen++;
    end
    check_val("oob_no_frame", 32'(busy_seen), 32'd0);
    write(1, 2'd1, 16'h0011);
    wait_idle(1, f);
    check_val("n3_frames", 32'(f), 32'd1);
    check_val("n3_latched", last_latch(1), 32'h0000_1100);
    check_val("n3_frame_len", 32'(frame_len[1]), 32'd102);
    check_val("n3_bits", 32'(frame_bits[1]), 32'd24);
    check_val("n3_latch_width", 32'(latch_len[1]), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
